alu_result_fifo: RTL and testbench

//  Downstream stage of the 16-bit ALU. Captures each ALU result {outW, zer, neg}

---
 rtl/alu_result_fifo.sv | 108 ++++++++++
 tb/tb_alu_result_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO behind the 16-bit ALU, with saturating zero/negative counters.
// Optional flag consistency checker enabled by defining ALU_FLAG_CHECK_EN.
module alu_result_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNTW  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_zer,
   input  logic                     in_neg,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_zer,
   output logic                     out_neg,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNTW-1:0]          zero_cnt,
   output logic [CNTW-1:0]          neg_cnt,
   output logic                     flag_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH+1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [CNTW-1:0]  r_zero_cnt;
   logic [CNTW-1:0]  r_neg_cnt;
   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic [WIDTH+1:0] w_head;

   assign w_empty   = (r_count == '0);
   assign in_ready  = (r_count != FULL_CNT);
   assign out_valid = !w_empty;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Head is muxed straight from storage and blanked when empty.
   assign w_head    = r_mem[r_rd_ptr];
   assign out_data  = w_empty ? '0   : w_head[WIDTH-1:0];
   assign out_zer   = w_empty ? 1'b0 : w_head[WIDTH];
   assign out_neg   = w_empty ? 1'b0 : w_head[WIDTH+1];

   assign count     = r_count;
   assign zero_cnt  = r_zero_cnt;
   assign neg_cnt   = r_neg_cnt;

   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= {in_neg, in_zer, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_zero_cnt <= '0;
         r_neg_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (in_zer && (r_zero_cnt != '1)) begin
               r_zero_cnt <= r_zero_cnt + CNTW'(1);
            end
            if (in_neg && (r_neg_cnt != '1)) begin
               r_neg_cnt <= r_neg_cnt + CNTW'(1);
            end
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

`ifdef ALU_FLAG_CHECK_EN
   logic r_flag_err;
   logic w_flag_bad;

   assign w_flag_bad = (in_zer != (in_data == '0)) || (in_neg != in_data[WIDTH-1]);
   assign flag_err   = r_flag_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flag_err <= 1'b0;
      end else if (w_push && w_flag_bad) begin
         r_flag_err <= 1'b1;
      end
   end
`else
   assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (default depth 4, 8-bit counters).
module tb_alu_result_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_zer;
   logic        in_neg;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_zer;
   logic        out_neg;
   logic [2:0]  count;
   logic [7:0]  zero_cnt;
   logic [7:0]  neg_cnt;
   logic        flag_err;

   int unsigned total = 0;
   int unsigned bad   = 0;

   alu_result_fifo #(.WIDTH(16), .DEPTH(4), .CNTW(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_zer(in_zer), .in_neg(in_neg),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_zer(out_zer), .out_neg(out_neg),
      .count(count), .zero_cnt(zero_cnt), .neg_cnt(neg_cnt), .flag_err(flag_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_zer = 1'b0; in_neg = 1'b0; out_ready = 1'b0;

      // reset state
      tick(); tick();
      rst = 1'b0; #1;
      check("rst_count", 32'(count), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_zero_cnt", 32'(zero_cnt), 0);
      check("rst_neg_cnt", 32'(neg_cnt), 0);

      // three pushes, no pops
      in_valid = 1'b1; in_data = 16'h0005; #1;
      check("t2_no_bypass", 32'(out_valid), 0);
      tick();
      check("t2_head_valid", 32'(out_valid), 1);
      check("t2_head_data", 32'(out_data), 32'h0005);
      in_data = 16'hFFFE; in_neg = 1'b1; tick();
      in_data = 16'h0000; in_neg = 1'b0; in_zer = 1'b1; tick();
      in_valid = 1'b0; in_zer = 1'b0; #1;
      check("t2_count3", 32'(count), 3);
      check("t2_zero_cnt", 32'(zero_cnt), 1);
      check("t2_neg_cnt", 32'(neg_cnt), 1);
      check("t2_flag_err_off", 32'(flag_err), 0);
      out_ready = 1'b1; #1;
      check("t2_pop0", 32'(out_data), 32'h0005);
      tick();
      check("t2_pop1", 32'(out_data), 32'hFFFE);
      check("t2_pop1_neg", 32'(out_neg), 1);
      tick();
      check("t2_pop2", 32'(out_data), 32'h0000);
      check("t2_pop2_zer", 32'(out_zer), 1);
      check("t2_pop2_valid", 32'(out_valid), 1);
      tick();
      out_ready = 1'b0; #1;
      check("t2_empty_count", 32'(count), 0);
      check("t2_empty_valid", 32'(out_valid), 0);
      check("t2_empty_data", 32'(out_data), 0);

      // fill, blocked fifth push, one-cycle pop
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 16'h0010 + 16'(i);
         tick();
      end
      in_data = 16'h0014; #1;
      check("t3_full_count", 32'(count), 4);
      check("t3_full_ready", 32'(in_ready), 0);
      tick();
      check("t3_blocked_count", 32'(count), 4);
      out_ready = 1'b1; #1;
      check("t3_ready_ignores_pop", 32'(in_ready), 0);
      tick();
      out_ready = 1'b0; #1;
      check("t3_after_pop_count", 32'(count), 3);
      check("t3_after_pop_head", 32'(out_data), 32'h0011);
      tick();
      in_valid = 1'b0; #1;
      check("t3_refill_count", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t3_drain", 32'(out_data), 32'h0011 + 32'(i));
         tick();
      end
      out_ready = 1'b0; #1;
      check("t3_drained", 32'(count), 0);

      // simultaneous push/pop at count=2 across pointer wrap
      in_valid = 1'b1;
      in_data = 16'h00A0; tick();
      in_data = 16'h00A1; tick();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 16'h00A2 + 16'(i); #1;
         check("t4_head", 32'(out_data), 32'h00A0 + 32'(i));
         tick();
         check("t4_count", 32'(count), 2);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("t4_tail", 32'(out_data), 32'h00AA + 32'(i));
         tick();
      end
      out_ready = 1'b0; #1;
      check("t4_empty", 32'(count), 0);

      // zero counter saturation
      rst = 1'b1; tick(); rst = 1'b0;
      in_valid = 1'b1; in_data = 16'h0000; in_zer = 1'b1; in_neg = 1'b0; out_ready = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 254) check("t5_zero_254", 32'(zero_cnt), 254);
         if (i == 255) check("t5_zero_255", 32'(zero_cnt), 255);
      end
      in_valid = 1'b0; in_zer = 1'b0;
      tick(); out_ready = 1'b0; #1;
      check("t5_zero_sat", 32'(zero_cnt), 255);
      check("t5_neg_cnt", 32'(neg_cnt), 0);
      check("t5_empty", 32'(count), 0);

`ifdef ALU_FLAG_CHECK_EN
      in_valid = 1'b1; in_data = 16'h0000; in_zer = 1'b0; in_neg = 1'b0; #1;
      check("t6_err_before", 32'(flag_err), 0);
      tick();
      check("t6_err_set", 32'(flag_err), 1);
      in_data = 16'h0003; tick();
      in_data = 16'h0004; tick();
      in_valid = 1'b0; #1;
      check("t6_err_sticky", 32'(flag_err), 1);
      check("t6_count3", 32'(count), 3);
      rst = 1'b1; tick(); rst = 1'b0; #1;
      check("t6_rst_count", 32'(count), 0);
      check("t6_rst_err", 32'(flag_err), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
